// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline control bundle: hazard/redirect requests in, PC and stage-register controls out
// Optional PIPE_CTRL_IRQ_EN adds the interrupt request/acknowledge signals.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              ex_jump_req_i;
    logic [ADDR_W-1:0] ex_jump_addr_i;
    logic [ADDR_W-1:0] ex_pc_i;
    logic              id_load_use_i;
    logic              div_busy_i;
    logic              mem_req_i;
    logic              mem_ack_i;
    logic              jump_ena_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              hold_ena_o;
    logic              hold_if_id_o;
    logic              hold_id_ex_o;
    logic              hold_ex_mem_o;
    logic              flush_if_id_o;
    logic              flush_id_ex_o;
    logic              bus_err_o;
    logic [31:0]       stall_cnt_o;
`ifdef PIPE_CTRL_IRQ_EN
    logic              irq_i;
    logic [ADDR_W-1:0] irq_vec_i;
    logic              irq_ack_o;
    logic [ADDR_W-1:0] epc_o;

    modport master (
        output ex_jump_req_i, ex_jump_addr_i, ex_pc_i, id_load_use_i, div_busy_i,
               mem_req_i, mem_ack_i, irq_i, irq_vec_i,
        input  jump_ena_o, jump_addr_o, hold_ena_o, hold_if_id_o, hold_id_ex_o,
               hold_ex_mem_o, flush_if_id_o, flush_id_ex_o, bus_err_o, stall_cnt_o,
               irq_ack_o, epc_o
    );
    modport slave (
        input  ex_jump_req_i, ex_jump_addr_i, ex_pc_i, id_load_use_i, div_busy_i,
               mem_req_i, mem_ack_i, irq_i, irq_vec_i,
        output jump_ena_o, jump_addr_o, hold_ena_o, hold_if_id_o, hold_id_ex_o,
               hold_ex_mem_o, flush_if_id_o, flush_id_ex_o, bus_err_o, stall_cnt_o,
               irq_ack_o, epc_o
    );
`else
    modport master (
        output ex_jump_req_i, ex_jump_addr_i, ex_pc_i, id_load_use_i, div_busy_i,
               mem_req_i, mem_ack_i,
        input  jump_ena_o, jump_addr_o, hold_ena_o, hold_if_id_o, hold_id_ex_o,
               hold_ex_mem_o, flush_if_id_o, flush_id_ex_o, bus_err_o, stall_cnt_o
    );
    modport slave (
        input  ex_jump_req_i, ex_jump_addr_i, ex_pc_i, id_load_use_i, div_busy_i,
               mem_req_i, mem_ack_i,
        output jump_ena_o, jump_addr_o, hold_ena_o, hold_if_id_o, hold_id_ex_o,
               hold_ex_mem_o, flush_if_id_o, flush_id_ex_o, bus_err_o, stall_cnt_o
    );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline redirect/stall arbiter with bus-wait timeout, post-redirect flush and stall counter
// Optional PIPE_CTRL_IRQ_EN adds interrupt redirect with EPC capture.
module pipe_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic       clk_100MHz,
    input  logic       arst_n,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FLUSH} state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);
    localparam logic [2:0]  FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam state_t      AFTER_REDIR = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;

    state_t      state, state_nx;
    logic [15:0] wait_cnt;
    logic [2:0]  flush_cnt;
    logic [31:0] stall_cnt;

    logic mem_new, timeout, wait_hold, stalled, issue_ok;
    logic take_div, take_jump, take_lu, take_irq, redirect;

    // wait_cnt counts the stalled cycles including the one that entered MEM_WAIT
    assign mem_new   = (state != S_MEM_WAIT) && bus.mem_req_i && !bus.mem_ack_i;
    assign timeout   = (state == S_MEM_WAIT) && !bus.mem_ack_i && (wait_cnt == TIMEOUT_VAL);
    assign wait_hold = (state == S_MEM_WAIT) && !bus.mem_ack_i && !timeout;
    assign stalled   = mem_new || wait_hold;
    // FLUSH cycles carry wrong-path requests, so nothing but the bus may act on them
    assign issue_ok  = !stalled && (state != S_FLUSH);
    assign take_div  = issue_ok && bus.div_busy_i;
    assign take_jump = issue_ok && bus.ex_jump_req_i && !bus.div_busy_i;
    assign take_lu   = issue_ok && bus.id_load_use_i && !bus.ex_jump_req_i && !bus.div_busy_i;
`ifdef PIPE_CTRL_IRQ_EN
    assign take_irq  = issue_ok && (state == S_RUN) && bus.irq_i && !bus.ex_jump_req_i
                       && !bus.div_busy_i && !bus.id_load_use_i;
`else
    assign take_irq  = 1'b0;
`endif
    assign redirect  = take_jump || take_irq;

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) state <= S_RUN;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN, S_FLUSH: begin
                if (mem_new)                                 state_nx = S_MEM_WAIT;
                else if (redirect)                           state_nx = AFTER_REDIR;
                else if (state == S_FLUSH && flush_cnt <= 3'd1) state_nx = S_RUN;
            end
            S_MEM_WAIT: begin
                if (!wait_hold) state_nx = redirect ? AFTER_REDIR : S_RUN;
            end
            default: state_nx = S_RUN;
        endcase
    end

    always_comb begin
        bus.jump_ena_o    = 1'b0;
        bus.jump_addr_o   = '0;
        bus.hold_ena_o    = 1'b0;
        bus.hold_if_id_o  = 1'b0;
        bus.hold_id_ex_o  = 1'b0;
        bus.hold_ex_mem_o = 1'b0;
        bus.flush_if_id_o = 1'b0;
        bus.flush_id_ex_o = 1'b0;
        bus.bus_err_o     = timeout;
        if (stalled) begin
            bus.hold_ena_o    = 1'b1;
            bus.hold_if_id_o  = 1'b1;
            bus.hold_id_ex_o  = 1'b1;
            bus.hold_ex_mem_o = 1'b1;
        end else if (redirect) begin
            bus.jump_ena_o    = 1'b1;
            bus.flush_if_id_o = 1'b1;
            bus.flush_id_ex_o = 1'b1;
`ifdef PIPE_CTRL_IRQ_EN
            bus.jump_addr_o   = take_irq ? bus.irq_vec_i : bus.ex_jump_addr_i;
`else
            bus.jump_addr_o   = bus.ex_jump_addr_i;
`endif
        end else if (state == S_FLUSH) begin
            bus.flush_if_id_o = 1'b1;
            bus.flush_id_ex_o = 1'b1;
        end else if (take_div) begin
            bus.hold_ena_o    = 1'b1;
            bus.hold_if_id_o  = 1'b1;
            bus.hold_id_ex_o  = 1'b1;
        end else if (take_lu) begin
            bus.hold_ena_o    = 1'b1;
            bus.hold_if_id_o  = 1'b1;
            bus.flush_id_ex_o = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            wait_cnt  <= '0;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (mem_new)        wait_cnt <= 16'd1;
            else if (wait_hold) wait_cnt <= wait_cnt + 16'd1;
            if (redirect)                                flush_cnt <= FLUSH_LOAD;
            else if (state == S_FLUSH && flush_cnt != 0) flush_cnt <= flush_cnt - 3'd1;
            if (bus.hold_ena_o && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
        end
    end
    assign bus.stall_cnt_o = stall_cnt;

`ifdef PIPE_CTRL_IRQ_EN
    logic [ADDR_W-1:0] epc;
    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n)       epc <= '0;
        else if (take_irq) epc <= bus.ex_pc_i;
    end
    assign bus.epc_o     = epc;
    assign bus.irq_ack_o = take_irq;
`endif
endmodule
